// File: rtl/instruction_fetch_pkg.sv
// Shared constants and FSM encoding for the IF stage.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam int          PC_STEP   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: one synchronous write port, one combinational read port.
module instruction_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [NB_ADDR-1:0] waddr_i,
  input  logic [NB_DATA-1:0] wdata_i,
  input  logic [NB_ADDR-1:0] raddr_i,
  output logic [NB_DATA-1:0] rdata_o
);

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  // Contents survive reset so a loaded program can be rerun.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, next-PC selection, IDLE/RUN/HALT control and the IF/ID register.
module instruction_fetch #(
  parameter int                  NB_DATA   = 32,
  parameter int                  NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0]  HALT_WORD = instruction_fetch_pkg::HALT_WORD
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_jump_addr,
  input  logic               i_branch,
  input  logic [NB_DATA-1:0] i_branch_addr,
  input  logic               i_mem_we,
  input  logic [NB_ADDR-1:0] i_mem_waddr,
  input  logic [NB_DATA-1:0] i_mem_wdata,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pcounter4,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_valid,
  output logic               o_halt
);
  import instruction_fetch_pkg::*;

  localparam int PC_W = NB_ADDR + 2;

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_plus4;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [NB_DATA-1:0] pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic [NB_DATA-1:0] fetch_word;
  logic               mem_we;
  logic               unused_addr_bits;

  // Loader writes only land while idle and out of reset.
  assign mem_we   = i_mem_we && (state_q == ST_IDLE) && i_rst_n;
  assign pc_plus4 = pc_q + PC_W'(PC_STEP);

  instruction_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_imem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (i_mem_waddr),
    .wdata_i (i_mem_wdata),
    .raddr_i (pc_q[PC_W-1:2]),
    .rdata_o (fetch_word)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        pc_d    = '0;
        instr_d = NOP_WORD;
        pc4_d   = '0;
        valid_d = 1'b0;
        if (i_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_branch) begin
          pc_d = {i_branch_addr[PC_W-1:2], 2'b00};
        end else if (i_jump) begin
          pc_d = {i_jump_addr[PC_W-1:2], 2'b00};
        end else if (!i_stall) begin
          pc_d = pc_plus4;
        end
        // A redirect overrides the stall hold, so the fetched word still enters IF/ID.
        if (i_flush) begin
          instr_d = NOP_WORD;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (!i_stall || i_branch || i_jump) begin
          instr_d = fetch_word;
          pc4_d   = {{(NB_DATA-PC_W){1'b0}}, pc_plus4};
          valid_d = 1'b1;
        end
        if ((fetch_word == HALT_WORD) && !i_stall && !i_flush) begin
          state_d = ST_HALT;
          pc_d    = pc_q;
        end
      end
      ST_HALT: begin
        instr_d = NOP_WORD;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign unused_addr_bits = ^{i_branch_addr[NB_DATA-1:PC_W], i_branch_addr[1:0],
                              i_jump_addr[NB_DATA-1:PC_W], i_jump_addr[1:0]};

  assign o_instruction = instr_q;
  assign o_pcounter4   = pc4_q;
  assign o_pc          = {{(NB_DATA-PC_W){1'b0}}, pc_q};
  assign o_valid       = valid_q;
  assign o_halt        = (state_q == ST_HALT);

endmodule
